// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the I2S / left-justified DAC transmit driver.
//   - serial format codes (I2S, left-justified)
//   - LRCK level that marks the left channel in each format
//   - serial-interface state encoding
//   - helper returning the left-channel LRCK level for a format
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam logic FMT_I2S = 1'b0;
    localparam logic FMT_LJ  = 1'b1;

    // LRCK level that identifies the left channel
    localparam logic LRCK_LEFT_I2S = 1'b0;
    localparam logic LRCK_LEFT_LJ  = 1'b1;

    // IDLE covers both "disabled" and "enabled, waiting for the first fall event"
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic lrck_left_level(input logic fmt);
        logic lvl;
        case (fmt)
            FMT_LJ:  lvl = LRCK_LEFT_LJ;
            default: lvl = LRCK_LEFT_I2S;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/dac_i2s_tx_bck_gen.sv
// -----------------------------------------------------------------------------
// i2s_bck_gen
// Bit-clock and word-clock generator driven by clock enables on clk_i.
// Ports:
//   clk_i        system clock
//   reset_i      synchronous active-high reset
//   enable_i     run (1) / idle and clear (0)
//   bck_o        registered bit clock
//   lrck_o       registered word clock
//   fall_evt_o   strobe: this cycle's edge takes BCK from 1 to 0
//   slot_start_o strobe: this fall event begins a new channel slot
//   left_o       qualifies slot_start_o: the slot being started is left
// -----------------------------------------------------------------------------
module i2s_bck_gen
    import dac_pkg::*;
#(
    parameter int   SLOT_BITS = 32,
    parameter int   BCK_DIV   = 2,
    parameter logic LEFT_LVL  = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic bck_o,
    output logic lrck_o,
    output logic fall_evt_o,
    output logic slot_start_o,
    output logic left_o
);

    localparam int DIV_W = (BCK_DIV   > 1) ? $clog2(BCK_DIV)   : 1;
    localparam int BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);

    state_e           state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             bck_q;
    logic             ch_q;      // 0 = left slot on the line, 1 = right
    logic             lrck_q;

    logic div_tc_s;
    logic fall_evt_s;
    logic slot_start_s;
    logic left_s;

    // Event strobes decoded from the current counter state
    always_comb begin
        div_tc_s     = (div_cnt_q == DIV_LAST);
        fall_evt_s   = enable_i & ~reset_i & div_tc_s & bck_q;
        // The first fall event after enable always opens a left slot
        slot_start_s = fall_evt_s & ((state_q == IDLE) | (bit_cnt_q == BIT_LAST));
        left_s       = (state_q == IDLE) | ch_q;
    end

    // Divider, bit counter, channel and word-clock registers
    always_ff @(posedge clk_i) begin
        if (reset_i || !enable_i) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bck_q     <= 1'b0;
            ch_q      <= 1'b0;
            lrck_q    <= ~LEFT_LVL;
        end else begin
            if (div_tc_s) begin
                div_cnt_q <= '0;
                bck_q     <= ~bck_q;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
            if (slot_start_s) begin
                state_q   <= RUN;
                bit_cnt_q <= '0;
                ch_q      <= ~left_s;
                lrck_q    <= left_s ? LEFT_LVL : ~LEFT_LVL;
            end else if (fall_evt_s) begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
        end
    end

    assign bck_o        = bck_q;
    assign lrck_o       = lrck_q;
    assign fall_evt_o   = fall_evt_s;
    assign slot_start_o = slot_start_s;
    assign left_o       = left_s;

endmodule

// File: rtl/dac_i2s_tx.sv
// -----------------------------------------------------------------------------
// dac_i2s_tx
// Audio DAC transmit driver: accepts stereo samples over valid/ready and
// serializes them MSB first on SDATA as I2S (FMT=0) or left-justified (FMT=1).
// Ports:
//   fpga_gclk    system clock, all logic on its rising edge
//   reset        synchronous active-high reset
//   enable       1 = run serial interface, 0 = idle and flush
//   s_left/right sample pair, two's complement
//   s_valid      sample pair valid
//   s_ready      holding register empty (registered)
//   BCK, LRCK    bit clock and word clock (registered)
//   SDATA        serial data (registered)
//   frame_start  one-cycle pulse at the start of the left slot
//   underrun     sticky: a frame was loaded with no sample available
// -----------------------------------------------------------------------------
module dac_i2s_tx
    import dac_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int SLOT_BITS = 32,
    parameter int BCK_DIV   = 2,
    parameter int FMT       = 0
) (
    input  logic              fpga_gclk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              BCK,
    output logic              LRCK,
    output logic              SDATA,
    output logic              frame_start,
    output logic              underrun
);

    localparam logic FMT_BIT  = (FMT == 1) ? FMT_LJ : FMT_I2S;
    localparam logic LEFT_LVL = lrck_left_level(FMT_BIT);

    // Left-align a sample in its slot; trailing slot bits are zero
    function automatic logic [SLOT_BITS-1:0] pad_slot(input logic [DATA_W-1:0] smp);
        return SLOT_BITS'(smp) << (SLOT_BITS - DATA_W);
    endfunction

    logic fall_evt_s;
    logic slot_start_s;
    logic left_s;
    logic load_s;
    logic accept_s;
    logic line_bit_s;
    logic [SLOT_BITS-1:0] slot_l_s;

    logic                 hold_full_q, hold_full_d;
    logic [DATA_W-1:0]    hold_l_q,    hold_l_d;
    logic [DATA_W-1:0]    hold_r_q,    hold_r_d;
    logic [SLOT_BITS-1:0] sh_q,        sh_d;
    logic [SLOT_BITS-1:0] right_q,     right_d;
    logic                 dly_q,       dly_d;
    logic                 sdata_q,     sdata_d;
    logic                 ready_q,     ready_d;
    logic                 fs_q,        fs_d;
    logic                 urun_q,      urun_d;

    i2s_bck_gen #(
        .SLOT_BITS (SLOT_BITS),
        .BCK_DIV   (BCK_DIV),
        .LEFT_LVL  (LEFT_LVL)
    ) u_bck_gen (
        .clk_i        (fpga_gclk),
        .reset_i      (reset),
        .enable_i     (enable),
        .bck_o        (BCK),
        .lrck_o       (LRCK),
        .fall_evt_o   (fall_evt_s),
        .slot_start_o (slot_start_s),
        .left_o       (left_s)
    );

    // Handshake, holding register, slot shifters and serial data next state
    always_comb begin
        accept_s    = s_valid & ready_q;
        load_s      = slot_start_s & left_s;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sh_d        = sh_q;
        right_d     = right_q;
        dly_d       = dly_q;
        sdata_d     = sdata_q;
        urun_d      = urun_q;
        fs_d        = 1'b0;
        line_bit_s  = 1'b0;
        slot_l_s    = '0;

        // The load reads the pre-accept holding state; no bypass
        if (load_s) begin
            if (hold_full_q) begin
                slot_l_s = pad_slot(hold_l_q);
                right_d  = pad_slot(hold_r_q);
            end else begin
                slot_l_s = '0;
                right_d  = '0;
                urun_d   = 1'b1;
            end
            hold_full_d = 1'b0;
            fs_d        = 1'b1;
        end else begin
            slot_l_s = '0;
        end

        if (accept_s) begin
            hold_full_d = 1'b1;
            hold_l_d    = s_left;
            hold_r_d    = s_right;
        end else begin
            hold_full_d = hold_full_d;
        end

        if (fall_evt_s) begin
            if (load_s) begin
                line_bit_s = slot_l_s[SLOT_BITS-1];
                sh_d       = {slot_l_s[SLOT_BITS-2:0], 1'b0};
            end else if (slot_start_s) begin
                line_bit_s = right_q[SLOT_BITS-1];
                sh_d       = {right_q[SLOT_BITS-2:0], 1'b0};
            end else begin
                line_bit_s = sh_q[SLOT_BITS-1];
                sh_d       = {sh_q[SLOT_BITS-2:0], 1'b0};
            end
            dly_d = line_bit_s;
            // I2S puts the MSB one BCK after the LRCK edge via dly_q
            if (FMT_BIT == FMT_LJ) begin
                sdata_d = line_bit_s;
            end else begin
                sdata_d = dly_q;
            end
        end else begin
            line_bit_s = 1'b0;
        end

        ready_d = enable & ~hold_full_d;
    end

    // State registers; disable clears everything including underrun
    always_ff @(posedge fpga_gclk) begin
        if (reset || !enable) begin
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sh_q        <= '0;
            right_q     <= '0;
            dly_q       <= 1'b0;
            sdata_q     <= 1'b0;
            ready_q     <= 1'b0;
            fs_q        <= 1'b0;
            urun_q      <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sh_q        <= sh_d;
            right_q     <= right_d;
            dly_q       <= dly_d;
            sdata_q     <= sdata_d;
            ready_q     <= ready_d;
            fs_q        <= fs_d;
            urun_q      <= urun_d;
        end
    end

    assign s_ready     = ready_q;
    assign SDATA       = sdata_q;
    assign frame_start = fs_q;
    assign underrun    = urun_q;

endmodule

// File: tb/tb_dac_i2s_tx.sv
module tb_dac_i2s_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        s_valid;
    logic [23:0] s_left;
    logic [23:0] s_right;

    logic rdy_i2s, bck_i2s, lrck_i2s, sd_i2s, fs_i2s, ur_i2s;
    logic rdy_lj,  bck_lj,  lrck_lj,  sd_lj,  fs_lj,  ur_lj;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_i2s_tx #(.DATA_W(24), .SLOT_BITS(32), .BCK_DIV(2), .FMT(0)) u_i2s (
        .fpga_gclk(clk), .reset(reset), .enable(enable),
        .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(rdy_i2s),
        .BCK(bck_i2s), .LRCK(lrck_i2s), .SDATA(sd_i2s),
        .frame_start(fs_i2s), .underrun(ur_i2s)
    );

    dac_i2s_tx #(.DATA_W(24), .SLOT_BITS(32), .BCK_DIV(2), .FMT(1)) u_lj (
        .fpga_gclk(clk), .reset(reset), .enable(enable),
        .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(rdy_lj),
        .BCK(bck_lj), .LRCK(lrck_lj), .SDATA(sd_lj),
        .frame_start(fs_lj), .underrun(ur_lj)
    );

    // Negedges until the next BCK rise; -1 if none within the budget
    task automatic wait_rise(output int cyc);
        logic prev;
        prev = bck_lj;
        cyc  = 0;
        while (cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (!prev && bck_lj) return;
            prev = bck_lj;
        end
        cyc = -1;
    endtask

    // Negedges until frame_start is seen; -1 if none within the budget
    task automatic wait_frame(output int cyc);
        cyc = 0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (fs_lj) return;
        end
        cyc = -1;
    endtask

    // Starting at a frame_start cycle, record SDATA on 64 BCK rises
    task automatic capture(output logic [63:0] lj_w, output logic [63:0] i2s_w,
                           output int nbits, output int fs_cnt,
                           output int rdy_cnt, output int lr_bad);
        logic prev;
        int   cyc;
        prev = bck_lj; nbits = 0; fs_cnt = 0; rdy_cnt = 0; lr_bad = 0; cyc = 0;
        lj_w = '0; i2s_w = '0;
        while (nbits < 64 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (fs_lj || fs_i2s) fs_cnt++;
            if (rdy_lj || rdy_i2s) rdy_cnt++;
            if (!prev && bck_lj) begin
                lj_w[63-nbits]  = sd_lj;
                i2s_w[63-nbits] = sd_i2s;
                if (lrck_lj !== (nbits < 32)) lr_bad++;
                if (lrck_i2s !== (nbits >= 32)) lr_bad++;
                nbits++;
            end
            prev = bck_lj;
        end
    endtask

    task automatic test_reset();
        int c;
        reset = 1'b1; enable = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bck_i2s, lrck_i2s, sd_i2s, rdy_i2s, ur_i2s, fs_i2s} !== 6'b010000) begin
                errors++; $display("FAIL reset_i2s got %b want 010000",
                    {bck_i2s, lrck_i2s, sd_i2s, rdy_i2s, ur_i2s, fs_i2s});
            end
            checks++;
            if ({bck_lj, lrck_lj, sd_lj, rdy_lj, ur_lj, fs_lj} !== 6'b000000) begin
                errors++; $display("FAIL reset_lj got %b want 000000",
                    {bck_lj, lrck_lj, sd_lj, rdy_lj, ur_lj, fs_lj});
            end
        end
        reset = 1'b0;
        wait_rise(c);
        checks++;
        if (c !== 2) begin errors++; $display("FAIL first_rise got %0d want 2", c); end
        wait_frame(c);
        checks++;
        if (c !== 2) begin errors++; $display("FAIL first_frame got %0d want 2", c); end
        checks++;
        if ({ur_lj, ur_i2s, lrck_lj, lrck_i2s} !== 4'b1110) begin
            errors++; $display("FAIL underrun_first got %b want 1110", {ur_lj, ur_i2s, lrck_lj, lrck_i2s});
        end
        wait_frame(c);
        checks++;
        if (c !== 256) begin errors++; $display("FAIL frame_period got %0d want 256", c); end
        wait_rise(c);
        wait_rise(c);
        checks++;
        if (c !== 4) begin errors++; $display("FAIL bck_period got %0d want 4", c); end
    endtask

    task automatic test_underrun_recover();
        int c, nb, fsn, rdn, lrb;
        logic [63:0] wl, wi;
        wait_frame(c);
        capture(wl, wi, nb, fsn, rdn, lrb);
        checks++;
        if (nb !== 64 || wl !== 64'h0 || wi !== 64'h0) begin
            errors++; $display("FAIL underrun_zeros got lj=%h i2s=%h bits=%0d want 0", wl, wi, nb);
        end
        checks++;
        if ({ur_lj, ur_i2s} !== 2'b11) begin
            errors++; $display("FAIL underrun_sticky got %b want 11", {ur_lj, ur_i2s});
        end
        enable = 1'b0; s_valid = 1'b1; s_left = 24'hA5F00F; s_right = 24'h123456;
        @(negedge clk);
        checks++;
        if ({ur_lj, ur_i2s, bck_lj, rdy_lj, sd_lj, lrck_lj, lrck_i2s} !== 7'b0000001) begin
            errors++; $display("FAIL disable_state got %b want 0000001",
                {ur_lj, ur_i2s, bck_lj, rdy_lj, sd_lj, lrck_lj, lrck_i2s});
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy_lj, rdy_i2s} !== 2'b11) begin
            errors++; $display("FAIL ready_after_enable got %b want 11", {rdy_lj, rdy_i2s});
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (rdy_lj !== 1'b0) begin errors++; $display("FAIL ready_after_accept got %b want 0", rdy_lj); end
        wait_frame(c);
        checks++;
        if (c !== 2 || fs_i2s !== 1'b1 || {ur_lj, ur_i2s} !== 2'b00) begin
            errors++; $display("FAIL frame_a_start got c=%0d fs_i2s=%b ur=%b want 2 1 00",
                c, fs_i2s, {ur_lj, ur_i2s});
        end
        capture(wl, wi, nb, fsn, rdn, lrb);
        checks++;
        if (wl !== 64'hA5F00F00_12345600) begin
            errors++; $display("FAIL lj_frame_a got %h want a5f00f0012345600", wl);
        end
        checks++;
        if (wi !== 64'h52F80780_091A2B00) begin
            errors++; $display("FAIL i2s_frame_a got %h want 52f80780091a2b00", wi);
        end
        checks++;
        if (nb !== 64 || fsn !== 0 || lrb !== 0) begin
            errors++; $display("FAIL frame_a_misc got bits=%0d fs=%0d lrbad=%0d want 64 0 0", nb, fsn, lrb);
        end
    endtask

    task automatic test_coincident();
        int c, nb, fsn, rdn, lrb;
        logic [63:0] wl, wi;
        checks++;
        if ({ur_lj, rdy_lj} !== 2'b01) begin
            errors++; $display("FAIL pre_coincident got %b want 01", {ur_lj, rdy_lj});
        end
        @(negedge clk);
        s_valid = 1'b1; s_left = 24'h800001; s_right = 24'h7FFFFE;
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if ({fs_lj, ur_lj, ur_i2s, rdy_lj} !== 4'b1110) begin
            errors++; $display("FAIL coincident_load got %b want 1110", {fs_lj, ur_lj, ur_i2s, rdy_lj});
        end
        capture(wl, wi, nb, fsn, rdn, lrb);
        checks++;
        if (nb !== 64 || wl !== 64'h0 || wi !== 64'h0) begin
            errors++; $display("FAIL coincident_zeros got lj=%h i2s=%h bits=%0d want 0", wl, wi, nb);
        end
        checks++;
        if (rdn !== 0) begin errors++; $display("FAIL ready_held_low got %0d want 0", rdn); end
        wait_frame(c);
        checks++;
        if (c !== 2 || {rdy_lj, ur_lj} !== 2'b11) begin
            errors++; $display("FAIL frame_b_start got c=%0d rdy_ur=%b want 2 11", c, {rdy_lj, ur_lj});
        end
        capture(wl, wi, nb, fsn, rdn, lrb);
        checks++;
        if (wl !== 64'h80000100_7FFFFE00) begin
            errors++; $display("FAIL lj_frame_b got %h want 800001007ffffe00", wl);
        end
        checks++;
        if (wi !== 64'h40000080_3FFFFF00) begin
            errors++; $display("FAIL i2s_frame_b got %h want 400000803fffff00", wi);
        end
    endtask

    task automatic test_disable_mid();
        int c, nb, fsn, rdn, lrb;
        logic [63:0] wl, wi;
        s_valid = 1'b1; s_left = 24'hFFFFFF; s_right = 24'hFFFFFF;
        @(negedge clk);
        s_valid = 1'b0;
        wait_frame(c);
        checks++;
        if (c !== 1) begin errors++; $display("FAIL frame_c_start got %0d want 1", c); end
        s_valid = 1'b1; s_left = 24'h0F0F0F; s_right = 24'hF0F0F0;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (169) @(negedge clk);
        checks++;
        if ({sd_lj, sd_i2s, lrck_lj, lrck_i2s} !== 4'b1101) begin
            errors++; $display("FAIL mid_right got %b want 1101", {sd_lj, sd_i2s, lrck_lj, lrck_i2s});
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({bck_lj, bck_i2s, lrck_lj, lrck_i2s, sd_lj, sd_i2s, rdy_lj, rdy_i2s} !== 8'b00010000) begin
            errors++; $display("FAIL mid_disable got %b want 00010000",
                {bck_lj, bck_i2s, lrck_lj, lrck_i2s, sd_lj, sd_i2s, rdy_lj, rdy_i2s});
        end
        s_valid = 1'b1; s_left = 24'hA5F00F; s_right = 24'h123456; enable = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_lj !== 1'b1) begin errors++; $display("FAIL reenable_ready got %b want 1", rdy_lj); end
        @(negedge clk);
        s_valid = 1'b0;
        wait_frame(c);
        checks++;
        if (c !== 2 || {lrck_lj, lrck_i2s} !== 2'b10) begin
            errors++; $display("FAIL reenable_frame got c=%0d lrck=%b want 2 10", c, {lrck_lj, lrck_i2s});
        end
        capture(wl, wi, nb, fsn, rdn, lrb);
        checks++;
        if (wl !== 64'hA5F00F00_12345600 || wi !== 64'h52F80780_091A2B00) begin
            errors++; $display("FAIL reenable_data got lj=%h i2s=%h want a5f00f0012345600 52f80780091a2b00", wl, wi);
        end
    endtask

    initial begin
        test_reset();
        test_underrun_recover();
        test_coincident();
        test_disable_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_i2s_tx.md
Name: dac_i2s_tx

Overview:
- Audio DAC transmit driver, the output-side counterpart of the ADC capture driver.
- Takes stereo parallel samples over a valid/ready handshake and serializes them onto SDATA as I2S or left-justified.
- Generates BCK and LRCK itself from fpga_gclk using clock enables; no derived clock domains.
- Sits between the DSP/sample pipeline and the external DAC pins.

Parameters:
- DATA_W, 24: sample width in bits, MSB first on the line.
- SLOT_BITS, 32: BCK periods per channel slot. Must be ≥ DATA_W. Bits beyond DATA_W are sent as 0.
- BCK_DIV, 2: fpga_gclk cycles per BCK half-period. Must be ≥ 2. BCK period = 2*BCK_DIV cycles.
- FMT, 0: 0 = I2S (1-BCK MSB delay, LRCK=0 is left); 1 = left-justified (no delay, LRCK=1 is left).

Ports:
- fpga_gclk  in  1  system clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = run the serial interface; 0 = idle and flush.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample, two's complement.
- s_valid  in  1  the sample pair on s_left/s_right is valid.
- s_ready  out  1  holding register empty; the pair is accepted when s_valid & s_ready.
- BCK  out  1  bit clock, registered.
- LRCK  out  1  word clock, registered.
- SDATA  out  1  serial data, registered.
- frame_start  out  1  one-cycle pulse in the cycle the left slot begins (shift registers loaded).
- underrun  out  1  sticky flag: a frame was loaded with no sample available.

Behaviour:
- Reset (reset=1): BCK=0, LRCK = left-level complement (FMT0: 1, FMT1: 0), SDATA=0, s_ready=0, frame_start=0, underrun=0. All counters and the holding register are cleared. Reset has priority over enable.
- Disabled (enable=0): same output values and clearing as reset, except that underrun is also cleared. The first BCK rising edge occurs BCK_DIV cycles after enable goes high. s_ready rises 1 cycle after enable goes high.
- Clock-enable counter div_cnt, 0..BCK_DIV-1:
  - At the terminal count, BCK toggles and div_cnt wraps.
  - A BCK 1→0 transition is the "fall event"; the DAC samples on the BCK rise.
- Bit counter bit_cnt, 0..SLOT_BITS-1, advances on each fall event.
- Channel toggle ch, toggles when bit_cnt wraps.
- LRCK is updated on the fall event where bit_cnt wraps. It equals the left level while ch=left.
- States:
  - IDLE (enable=0).
  - RUN: the first fall event after enable starts the left slot with bit_cnt=0.
  - RUN→IDLE immediately when enable=0, mid-frame or not. No partial-frame completion.
- Frame load, on the fall event starting the left slot:
  - If the holding register is full, copy left and right into shift registers and mark the holding register empty.
  - If it is empty, load zeros and set underrun.
  - frame_start pulses in that cycle.
- The right shift register is used when the right slot begins.
- Handshake:
  - s_ready = enabled & holding register empty.
  - An accept writes the holding register in the cycle after it occurs.
  - If an accept and a frame load coincide, the load sees the pre-accept state: underrun if empty, and the accepted pair goes to the next frame. There is no bypass path.
  - The holding register is one-deep, so s_ready stays 0 until the next frame load after a fill.
- Serial data:
  - On each fall event, the next bit, MSB first, goes to the line. Bits with index ≥ DATA_W in the slot are 0.
  - FMT=1: SDATA changes together with LRCK, so the MSB is coincident with the LRCK edge.
  - FMT=0: SDATA passes through an extra 1-bit register clocked on fall events, so the MSB appears one BCK after the LRCK edge. The last bit of a slot spills into bit 0 of the next slot; it is padding 0 when SLOT_BITS > DATA_W.
- Latency, accept to first SDATA bit:
  - Ready window up to one frame = 2*SLOT_BITS*2*BCK_DIV cycles.
  - Plus 0 BCK (FMT=1) or 1 BCK (FMT=0) after the left-slot LRCK edge.
- Every output is a flop; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package dac_pkg:
  - FMT_I2S=0 and FMT_LJ=1.
  - Left-level LRCK constants per format.
  - State encoding localparams IDLE and RUN.
- One natural sub-module, i2s_bck_gen:
  - Contains div_cnt, bit_cnt and ch.
  - Outputs registered BCK and LRCK, a fall_evt strobe, and slot_start/left strobes.
- dac_i2s_tx keeps the handshake, holding register, shifters, SDATA and flags.

Test Plan (DATA_W=24, SLOT_BITS=32, BCK_DIV=2 unless noted):
- Reset held 3 cycles while enabled → BCK=0, LRCK=1, SDATA=0, s_ready=0, underrun=0 throughout. BCK period after release is 4 cycles and the frame is 256 cycles.
- FMT=1, s_left=24'hA5F00F, s_right=24'h123456 accepted before the first frame → on BCK rises after LRCK→1, SDATA reads 1010_0101_1111_0000_0000_1111 then 8 zeros. After LRCK→0 it reads 0001_0010_0011_0100_0101_0110 then 8 zeros. frame_start pulses once.
- FMT=0, same samples → every bit is delayed by exactly 1 BCK relative to the LRCK edge, and LRCK=0 during left. Slot bit 0 is 0.
- No s_valid after enable → zeros on SDATA and underrun=1 at the first frame_start; it stays 1 until enable=0. Then hold s_valid=1 and raise enable → s_ready=1 one cycle after enable, and the accept completes before the next frame. The frame_start after the accept carries that sample.
- s_valid asserted in exactly the frame_start cycle with the holding register empty → underrun=1 and the frame is zeros. The next frame carries the sample; s_ready stays 0 between the accept and the next load.
- enable dropped mid right slot (bit_cnt=10) → the next cycle shows BCK=0, LRCK idle, SDATA=0, s_ready=0. Re-enabling restarts with a left slot and bit_cnt=0.
